// File: rtl/ec_dresp_unit_pkg.sv
// Shared types and constants for the EC-stage data response unit.
package ec_dresp_unit_pkg;

    typedef enum logic [1:0] {
        ECDR_IDLE = 2'd0,
        ECDR_WAIT = 2'd1,
        ECDR_HOLD = 2'd2
    } ecdr_state_e;

    localparam logic [3:0] LSV_BYTE = 4'b0001;
    localparam logic [3:0] LSV_HALF = 4'b0011;
    localparam logic [3:0] LSV_WORD = 4'b1111;

endpackage

// File: rtl/ec_dresp_unit_if.sv
// EC request fields, data-bus response and stall/result signals of the EC response unit.
interface ec_dresp_unit_if;

    logic        refresh;
    logic        ext_stall;
    logic        ec_data_req;
    logic        ec_load;
    logic        ec_loadX;
    logic [3:0]  ec_lsV;
    logic [1:0]  ec_data_addr;
    logic        data_ok;
    logic [31:0] data_rdata;
    logic        ec_stall_req;
    logic        ec_rdata_vld;
    logic [31:0] ec_rdata;
    logic [31:0] perf_wait_cyc;

    modport master (
        output refresh, ext_stall, ec_data_req, ec_load, ec_loadX, ec_lsV, ec_data_addr,
               data_ok, data_rdata,
        input  ec_stall_req, ec_rdata_vld, ec_rdata, perf_wait_cyc
    );

    modport slave (
        input  refresh, ext_stall, ec_data_req, ec_load, ec_loadX, ec_lsV, ec_data_addr,
               data_ok, data_rdata,
        output ec_stall_req, ec_rdata_vld, ec_rdata, perf_wait_cyc
    );

endinterface

// File: rtl/ec_dresp_unit_load_ext.sv
// Combinational load-data extraction: selects byte/half by address offset and sign/zero-extends.
module ec_dresp_unit_load_ext
    import ec_dresp_unit_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [3:0]  lsv,
    input  logic [1:0]  addr,
    input  logic        zero_ext,
    output logic [31:0] result
);

    logic [15:0] sh;

    // Only the low half of the shifted word can ever be selected.
    assign sh = 16'(rdata >> {addr, 3'b000});

    always_comb begin
        case (lsv)
            LSV_BYTE: result = {{24{~zero_ext & sh[7]}},  sh[7:0]};
            LSV_HALF: result = {{16{~zero_ext & sh[15]}}, sh[15:0]};
            default:  result = rdata;
        endcase
    end

endmodule

// File: rtl/ec_dresp_unit.sv
// EC-stage data response unit: stalls EC until data_ok, buffers held responses, drains flushed ones.
// Optional feature macro: ECDR_PERF_EN (stall-cycle counter on perf_wait_cyc).
module ec_dresp_unit
    import ec_dresp_unit_pkg::*;
#(
    parameter int DISC_W = 2
) (
    input logic           clk,
    input logic           resetn,
    ec_dresp_unit_if.slave bus
);

    localparam logic [DISC_W-1:0] DISC_MAX = '1;

    ecdr_state_e       state, state_n;
    logic [DISC_W-1:0] disc_cnt;
    logic [31:0]       rsp_buf;
    logic [31:0]       byp_data, buf_data;
    logic              mine, drop, outstanding, buf_load, disc_inc;
    logic              stall_req, rdata_vld;
    logic [31:0]       rdata;

    // While flushed responses are still in flight, every data_ok belongs to one of them.
    assign drop = bus.data_ok & (disc_cnt != '0);
    assign mine = bus.ec_data_req & bus.data_ok & (disc_cnt == '0);

    ec_dresp_unit_load_ext u_byp_ext (
        .rdata    (bus.data_rdata),
        .lsv      (bus.ec_lsV),
        .addr     (bus.ec_data_addr),
        .zero_ext (bus.ec_loadX),
        .result   (byp_data)
    );

    ec_dresp_unit_load_ext u_buf_ext (
        .rdata    (rsp_buf),
        .lsv      (bus.ec_lsV),
        .addr     (bus.ec_data_addr),
        .zero_ext (bus.ec_loadX),
        .result   (buf_data)
    );

    always_comb begin
        // NOTE: every output gets a default first so no path through the case infers a latch.
        state_n     = state;
        stall_req   = 1'b0;
        rdata_vld   = 1'b0;
        rdata       = byp_data;
        buf_load    = 1'b0;
        outstanding = 1'b0;
        unique case (state)
            ECDR_IDLE: begin
                if (bus.ec_data_req && !mine) begin
                    stall_req   = 1'b1;
                    outstanding = 1'b1;
                    state_n     = ECDR_WAIT;
                end else if (mine) begin
                    rdata_vld = bus.ec_load;
                    if (bus.ext_stall) begin
                        buf_load = 1'b1;
                        state_n  = ECDR_HOLD;
                    end
                end
            end
            ECDR_WAIT: begin
                if (mine) begin
                    rdata_vld = bus.ec_load;
                    buf_load  = 1'b1;
                    state_n   = bus.ext_stall ? ECDR_HOLD : ECDR_IDLE;
                end else begin
                    stall_req   = 1'b1;
                    outstanding = 1'b1;
                end
            end
            ECDR_HOLD: begin
                rdata_vld = bus.ec_load;
                rdata     = buf_data;
                if (!bus.ext_stall) state_n = ECDR_IDLE;
            end
            default: state_n = ECDR_IDLE;
        endcase
        // A flushed instruction whose response is still outstanding leaves one to drain later.
        disc_inc = bus.refresh & outstanding;
        if (bus.refresh) begin
            state_n   = ECDR_IDLE;
            rdata_vld = 1'b0;
        end
        if (!resetn) begin
            stall_req = 1'b0;
            rdata_vld = 1'b0;
        end
        if (!rdata_vld) rdata = '0;
    end

    assign bus.ec_stall_req = stall_req;
    assign bus.ec_rdata_vld = rdata_vld;
    assign bus.ec_rdata     = rdata;

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ECDR_IDLE;
            disc_cnt <= '0;
            rsp_buf  <= '0;
        end else begin
            state <= state_n;
            if (buf_load) rsp_buf <= bus.data_rdata;
            if (disc_inc && !drop) begin
                if (disc_cnt != DISC_MAX) disc_cnt <= disc_cnt + DISC_W'(1);
            end else if (drop && !disc_inc) begin
                disc_cnt <= disc_cnt - DISC_W'(1);
            end
        end
    end

    a_disc_ovf: assert property (@(posedge clk) disable iff (!resetn)
        !(disc_inc && !drop && disc_cnt == DISC_MAX))
        else $error("ec_dresp_unit: discard counter overflow");

`ifdef ECDR_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (!resetn)        perf_q <= '0;
        else if (stall_req) perf_q <= perf_q + 32'd1;
    end

    assign bus.perf_wait_cyc = perf_q;
`else
    assign bus.perf_wait_cyc = '0;
`endif

endmodule

// File: tb/tb_ec_dresp_unit.sv
// Scoreboard bench for ec_dresp_unit: stimulus pushes expected load results, a monitor pops on vld.
module tb_ec_dresp_unit;
    import ec_dresp_unit_pkg::*;

    typedef struct {
        logic [3:0]  lsv;
        logic [1:0]  addr;
        logic        zx;
        logic [31:0] rd;
        logic [31:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic resetn;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [31:0] exp_q[$];

    ec_dresp_unit_if ifc();

    ec_dresp_unit #(.DISC_W(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifc)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic req, input logic load, input logic zx, input logic [3:0] lsv,
                         input logic [1:0] addr, input logic dok, input logic [31:0] rd,
                         input logic ext, input logic refr);
        ifc.ec_data_req  = req;
        ifc.ec_load      = load;
        ifc.ec_loadX     = zx;
        ifc.ec_lsV       = lsv;
        ifc.ec_data_addr = addr;
        ifc.data_ok      = dok;
        ifc.data_rdata   = rd;
        ifc.ext_stall    = ext;
        ifc.refresh      = refr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, LSV_WORD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // One clock cycle: check stall mid-cycle, then step to just after the next rising edge.
    task automatic cyc(input logic exp_stall, input string name);
        @(negedge clk);
        check(ifc.ec_stall_req === exp_stall, name, {31'b0, ifc.ec_stall_req}, {31'b0, exp_stall});
        @(posedge clk);
        #1;
    endtask

    // Monitor: every presented load result must match the oldest expected entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && ifc.ec_rdata_vld === 1'b1) begin
            check(exp_q.size() != 0, "vld_expected", ifc.ec_rdata, 32'h0);
            if (exp_q.size() != 0) begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check(ifc.ec_rdata === e, "ec_rdata", ifc.ec_rdata, e);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs = '{
            '{LSV_BYTE, 2'd0, 1'b0, 32'h0000007F, 32'h0000007F},
            '{LSV_BYTE, 2'd1, 1'b1, 32'h0000F000, 32'h000000F0},
            '{LSV_HALF, 2'd0, 1'b0, 32'h12348001, 32'hFFFF8001},
            '{LSV_HALF, 2'd2, 1'b0, 32'h7FFF0000, 32'h00007FFF},
            '{LSV_WORD, 2'd2, 1'b0, 32'hDEADBEEF, 32'hDEADBEEF},
            '{LSV_BYTE, 2'd2, 1'b1, 32'h00AB0000, 32'h000000AB}
        };

        resetn = 1'b0;
        idle();
        @(negedge clk);
        check(ifc.ec_stall_req === 1'b0, "rst_stall", {31'b0, ifc.ec_stall_req}, 32'h0);
        check(ifc.ec_rdata_vld === 1'b0, "rst_vld", {31'b0, ifc.ec_rdata_vld}, 32'h0);
        check(ifc.ec_rdata === 32'h0, "rst_rdata", ifc.ec_rdata, 32'h0);
        check(ifc.perf_wait_cyc === 32'h0, "rst_perf", ifc.perf_wait_cyc, 32'h0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc(1'b0, "idle_stall");

        // T1: lb at offset 3, response in first EC cycle.
        drive(1'b1, 1'b1, 1'b0, LSV_BYTE, 2'd3, 1'b1, 32'h80123456, 1'b0, 1'b0);
        exp_q.push_back(32'hFFFFFF80);
        cyc(1'b0, "t1_stall");
        idle();
        cyc(1'b0, "t1_idle");

        // T2: lhu at offset 2, response three cycles late.
        drive(1'b1, 1'b1, 1'b1, LSV_HALF, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, "t2_wait_stall");
        ifc.data_ok    = 1'b1;
        ifc.data_rdata = 32'hBEEF0000;
        exp_q.push_back(32'h0000BEEF);
        cyc(1'b0, "t2_resp_stall");
        idle();
        cyc(1'b0, "t2_idle");

        // T3: lw answered while the pipe is held for two cycles.
        drive(1'b1, 1'b1, 1'b0, LSV_WORD, 2'd0, 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        exp_q.push_back(32'hCAFEF00D);
        cyc(1'b0, "t3_resp_stall");
        ifc.data_ok    = 1'b0;
        ifc.data_rdata = 32'h0;
        exp_q.push_back(32'hCAFEF00D);
        cyc(1'b0, "t3_hold_stall");
        ifc.ext_stall = 1'b0;
        exp_q.push_back(32'hCAFEF00D);
        cyc(1'b0, "t3_release_stall");
        idle();
        cyc(1'b0, "t3_idle");

        // T4: flush in WAIT; the next load must skip the stale response.
        drive(1'b1, 1'b1, 1'b0, LSV_WORD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, "t4_wait_stall");
        ifc.refresh = 1'b1;
        cyc(1'b1, "t4_refresh_stall");
        drive(1'b1, 1'b1, 1'b0, LSV_WORD, 2'd0, 1'b1, 32'h11111111, 1'b0, 1'b0);
        cyc(1'b1, "t4_drop_stall");
        ifc.data_rdata = 32'h22222222;
        exp_q.push_back(32'h22222222);
        cyc(1'b0, "t4_resp_stall");
        idle();
        cyc(1'b0, "t4_idle");

        // T5: flush coincident with the owned response; nothing left to drain.
        drive(1'b1, 1'b1, 1'b0, LSV_WORD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, "t5_wait_stall");
        drive(1'b1, 1'b1, 1'b0, LSV_WORD, 2'd0, 1'b1, 32'h33333333, 1'b0, 1'b1);
        @(negedge clk);
        check(ifc.ec_stall_req === 1'b0, "t5_refresh_stall", {31'b0, ifc.ec_stall_req}, 32'h0);
        check(ifc.ec_rdata_vld === 1'b0, "t5_refresh_vld", {31'b0, ifc.ec_rdata_vld}, 32'h0);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b1, 1'b0, LSV_WORD, 2'd0, 1'b1, 32'h44444444, 1'b0, 1'b0);
        exp_q.push_back(32'h44444444);
        cyc(1'b0, "t5_next_stall");
        idle();
        cyc(1'b0, "t5_idle");

        // Extraction table, one load per cycle with immediate response.
        foreach (vecs[k]) begin
            drive(1'b1, 1'b1, vecs[k].zx, vecs[k].lsv, vecs[k].addr, 1'b1, vecs[k].rd, 1'b0, 1'b0);
            exp_q.push_back(vecs[k].exp);
            cyc(1'b0, "ext_stall_req");
        end
        idle();
        cyc(1'b0, "ext_idle");
`ifdef ECDR_PERF_EN
        check(ifc.perf_wait_cyc === 32'd7, "perf_before_t6", ifc.perf_wait_cyc, 32'd7);
`endif

        // T6: sw answered one cycle late; no load result.
        drive(1'b1, 1'b0, 1'b0, LSV_WORD, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b1, "t6_wait_stall");
        ifc.data_ok    = 1'b1;
        ifc.data_rdata = 32'h5555AAAA;
        cyc(1'b0, "t6_resp_stall");
        idle();
        cyc(1'b0, "t6_idle");
        cyc(1'b0, "tail_idle");

        check(exp_q.size() == 0, "pending_rsp", 32'(exp_q.size()), 32'h0);
`ifdef ECDR_PERF_EN
        check(ifc.perf_wait_cyc === 32'd8, "perf_total", ifc.perf_wait_cyc, 32'd8);
`else
        check(ifc.perf_wait_cyc === 32'd0, "perf_tied", ifc.perf_wait_cyc, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
